mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 24 ++
 rtl/mem_responder_ram.sv | 40 ++++
 rtl/mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_mem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the block memory responder: FSM state encoding,
// burst geometry and a small beat helper.
// Optional feature macro used by this slice: MEM_RESP_LATENCY_EN.
package mem_responder_pkg;

  // A block is four 32-bit words; the beat counter indexes a word in a block.
  localparam int BEAT_BITS     = 2;
  localparam int BLOCK_WORDS   = 4;
  localparam int WAIT_CNT_BITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // True when the beat index addresses the final word of a block.
  function automatic logic is_last_beat(input logic [BEAT_BITS-1:0] beat);
    return beat == BEAT_BITS'(BLOCK_WORDS - 1);
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Word storage for the memory responder: single port, synchronous read,
// 32-bit write. The array itself is never reset so a reset mid-burst keeps
// whatever was already written; only the read-data register is cleared.
module resp_word_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Array write port.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      mem_q[i_addr] <= i_wdata;
    end
  end

  // Read register only moves on a read access, so it holds between beats.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rdata_q <= '0;
    end else if (i_en && !i_we) begin
      rdata_q <= mem_q[i_addr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Block memory responder for a cache refill/eviction port. Accepts one
// 4-word block request at a time from IDLE, then streams four read beats
// or absorbs four write beats and pulses o_done.
// Optional feature macro: MEM_RESP_LATENCY_EN adds a WAIT state that
// inserts LATENCY wait cycles between acceptance and the first beat.
//
// Handshake: a request is taken on a rising edge where o_ready_mm=1 and
// i_req=1; o_req_ack pulses for the following cycle. Requests seen while
// busy are dropped, never queued. Write beats are taken on every edge in
// WRITE where i_wvalid=1 (no ready back-pressure, no timeout); read beats
// are presented on o_rdata/o_beat for exactly the cycles o_rvalid=1.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 i_req,
  input  logic                 i_req_we,
  input  logic [ADDR_BITS-5:0] i_req_addr,
  input  logic [31:0]          i_wdata,
  input  logic                 i_wvalid,
  output logic                 o_ready_mm,
  output logic                 o_req_ack,
  output logic [31:0]          o_rdata,
  output logic                 o_rvalid,
  output logic [1:0]           o_beat,
  output logic                 o_done,
  output logic [2:0]           o_dbg_state
);

  localparam int BLK_BITS  = ADDR_BITS - 4;
  localparam int WORD_BITS = ADDR_BITS - 2;

  // Out-of-range wait counts would not fit the 4-bit counter.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be within 1..15");
  end

  state_e                 state_q,  state_d;
  logic [BLK_BITS-1:0]    block_q,  block_d;
  logic                   we_q,     we_d;
  logic [BEAT_BITS-1:0]   beat_q,   beat_d;
  logic [BEAT_BITS-1:0]   rbeat_q,  rbeat_d;
  logic                   ack_q,    ack_d;
  logic                   rvalid_q, rvalid_d;
  logic                   done_q,   done_d;
`ifdef MEM_RESP_LATENCY_EN
  logic [WAIT_CNT_BITS-1:0] wait_q, wait_d;
`endif

  logic                 ram_en;
  logic                 ram_we;
  logic [WORD_BITS-1:0] ram_addr;
  logic [31:0]          ram_rdata;

  // Word address is the latched block with the beat as the low two bits.
  assign ram_addr = {block_q, beat_q};

  // State and control registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      block_q  <= '0;
      we_q     <= 1'b0;
      beat_q   <= '0;
      rbeat_q  <= '0;
      ack_q    <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef MEM_RESP_LATENCY_EN
      wait_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      block_q  <= block_d;
      we_q     <= we_d;
      beat_q   <= beat_d;
      rbeat_q  <= rbeat_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
`ifdef MEM_RESP_LATENCY_EN
      wait_q   <= wait_d;
`endif
    end
  end

  // Next-state, beat sequencing and memory port control.
  always_comb begin
    state_d  = state_q;
    block_d  = block_q;
    we_d     = we_q;
    beat_d   = beat_q;
    rbeat_d  = rbeat_q;
    ack_d    = 1'b0;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
`ifdef MEM_RESP_LATENCY_EN
    wait_d   = wait_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          block_d = i_req_addr;
          we_d    = i_req_we;
          beat_d  = '0;
          ack_d   = 1'b1;
`ifdef MEM_RESP_LATENCY_EN
          // Counter reaches zero on the last of LATENCY wait cycles.
          wait_d  = WAIT_CNT_BITS'(LATENCY - 1);
          state_d = ST_WAIT;
`else
          state_d = i_req_we ? ST_WRITE : ST_READ;
`endif
        end
      end

`ifdef MEM_RESP_LATENCY_EN
      ST_WAIT: begin
        if (wait_q == '0) begin
          state_d = we_q ? ST_WRITE : ST_READ;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
`endif

      ST_READ: begin
        // One read issued per cycle; data and valid appear together next cycle.
        ram_en   = 1'b1;
        rvalid_d = 1'b1;
        rbeat_d  = beat_q;
        beat_d   = beat_q + 1'b1;
        if (is_last_beat(beat_q)) begin
          state_d = ST_DONE;
        end
      end

      ST_WRITE: begin
        // A cycle without i_wvalid simply stalls on the current beat.
        if (i_wvalid) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (is_last_beat(beat_q)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  resp_word_ram #(
    .AW (WORD_BITS),
    .DW (32)
  ) u_ram (
    .clk     (clk),
    .nrst    (nrst),
    .i_en    (ram_en),
    .i_we    (ram_we),
    .i_addr  (ram_addr),
    .i_wdata (i_wdata),
    .o_rdata (ram_rdata)
  );

  assign o_ready_mm  = (state_q == ST_IDLE);
  assign o_req_ack   = ack_q;
  assign o_rdata     = ram_rdata;
  assign o_rvalid    = rvalid_q;
  // Writes report the beat being accepted; reads report the beat on o_rdata.
  assign o_beat      = we_q ? beat_q : rbeat_q;
  assign o_done      = done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: block writes/reads against a word
// model, read beats scoreboarded through an expected queue, cycle-exact
// latency checks, busy-request, mid-write reset and top-block cases.
module tb_mem_responder;

  localparam int ADDR_BITS = 12;
  localparam int LATENCY   = 4;
  localparam int BLK_BITS  = ADDR_BITS - 4;
  localparam int DEPTH     = 1 << (ADDR_BITS - 2);
`ifdef MEM_RESP_LATENCY_EN
  localparam int EXP_WAIT  = LATENCY;
`else
  localparam int EXP_WAIT  = 0;
`endif

  logic                clk;
  logic                nrst;
  logic                i_req;
  logic                i_req_we;
  logic [BLK_BITS-1:0] i_req_addr;
  logic [31:0]         i_wdata;
  logic                i_wvalid;
  logic                o_ready_mm;
  logic                o_req_ack;
  logic [31:0]         o_rdata;
  logic                o_rvalid;
  logic [1:0]          o_beat;
  logic                o_done;
  logic [2:0]          o_dbg_state;

  int n_compared;
  int n_mismatched;

  logic [31:0] model [DEPTH];
  logic [33:0] exp_q [$];

  mem_responder #(
    .ADDR_BITS (ADDR_BITS),
    .LATENCY   (LATENCY)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .i_req       (i_req),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_wdata     (i_wdata),
    .i_wvalid    (i_wvalid),
    .o_ready_mm  (o_ready_mm),
    .o_req_ack   (o_req_ack),
    .o_rdata     (o_rdata),
    .o_rvalid    (o_rvalid),
    .o_beat      (o_beat),
    .o_done      (o_done),
    .o_dbg_state (o_dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every read beat is popped and compared on the falling edge.
  always @(negedge clk) begin
    if (nrst && o_rvalid) begin
      if (exp_q.size() == 0) begin
        check_val("rd_unexpected_beat", 64'(o_rdata), 64'hDEAD_0000);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check_val("rd_beat_idx", 64'(o_beat), 64'(e[33:32]));
        check_val("rd_data", 64'(o_rdata), 64'(e[31:0]));
      end
    end
  end

  // Driver: block write; gap_at inserts one idle cycle before that beat.
  task automatic do_write(input logic [BLK_BITS-1:0] blk, input logic [31:0] w0,
                          input logic [31:0] w1, input logic [31:0] w2,
                          input logic [31:0] w3, input int gap_at);
    logic [31:0] w [4];
    int early_done;
    int wait_cyc;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    early_done = 0;
    i_req = 1'b1; i_req_we = 1'b1; i_req_addr = blk;
    @(posedge clk);
    @(negedge clk);
    check_val("wr_ack", 64'(o_req_ack), 64'd1);
    check_val("wr_busy_ready", 64'(o_ready_mm), 64'd0);
    i_req = 1'b0;
    repeat (EXP_WAIT) begin
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == gap_at) begin
        i_wvalid = 1'b0;
        i_wdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        if (o_done) early_done++;
      end
      i_wvalid = 1'b1;
      i_wdata  = w[i];
      model[{blk, 2'(i)}] = w[i];
      @(negedge clk);
      if (o_done) early_done++;
    end
    i_wvalid = 1'b0;
    wait_cyc = 0;
    while (!o_done && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_val("wr_early_done", 64'(early_done), 64'd0);
    check_val("wr_done_cycle", 64'(wait_cyc), 64'd1);
  endtask

  // Driver: block read with cycle-exact latency checks; hold_req keeps i_req
  // asserted for the whole burst to exercise the busy-drop behaviour.
  task automatic do_read(input logic [BLK_BITS-1:0] blk, input bit hold_req);
    int cyc, first_rv, done_cyc, extra_acks, busy_ready;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({2'(i), model[{blk, 2'(i)}]});
    end
    i_req = 1'b1; i_req_we = 1'b0; i_req_addr = blk;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    check_val("rd_ack", 64'(o_req_ack), 64'd1);
    if (!hold_req) i_req = 1'b0;
    first_rv = -1; done_cyc = -1; extra_acks = 0; busy_ready = 0;
    while (done_cyc < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (o_req_ack) extra_acks++;
      if (o_rvalid && first_rv < 0) first_rv = cyc;
      if (o_done) begin
        done_cyc = cyc;
        i_req = 1'b0;
      end else if (o_ready_mm) begin
        busy_ready++;
      end
    end
    i_req = 1'b0;
    check_val("rd_first_rvalid_cycle", 64'(first_rv), 64'(2 + EXP_WAIT));
    check_val("rd_done_cycle", 64'(done_cyc), 64'(6 + EXP_WAIT));
    check_val("rd_extra_ack", 64'(extra_acks), 64'd0);
    check_val("rd_ready_while_busy", 64'(busy_ready), 64'd0);
    check_val("rd_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, 64'(o_ready_mm), 64'd1);
    check_val({tag, "_ack"}, 64'(o_req_ack), 64'd0);
    check_val({tag, "_rvalid"}, 64'(o_rvalid), 64'd0);
    check_val({tag, "_done"}, 64'(o_done), 64'd0);
    check_val({tag, "_beat"}, 64'(o_beat), 64'd0);
    check_val({tag, "_rdata"}, 64'(o_rdata), 64'd0);
    check_val({tag, "_state"}, 64'(o_dbg_state), 64'd0);
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    nrst = 1'b0;
    i_req = 1'b0; i_req_we = 1'b0; i_req_addr = '0;
    i_wdata = '0; i_wvalid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    nrst = 1'b1;
    @(negedge clk);

    // Stray write beats in IDLE must not start or corrupt anything.
    i_wvalid = 1'b1; i_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check_val("idle_wvalid_ready", 64'(o_ready_mm), 64'd1);
    i_wvalid = 1'b0;

    // Preload block 0x05 and read it back.
    do_write(8'h05, 32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333, -1);
    do_read(8'h05, 1'b0);

    // Write with a gap before the third beat, then read back.
    do_write(8'h3F, 32'h11, 32'h22, 32'h33, 32'h44, 2);
    do_read(8'h3F, 1'b0);

    // Request held high during a read: dropped, not queued.
    do_read(8'h05, 1'b1);
    @(negedge clk);
    check_val("busy_no_restart", 64'(o_ready_mm), 64'd1);

    // Reset mid-write after two beats to block 0x01.
    do_write(8'h01, 32'h0101_0000, 32'h0101_0001, 32'h0101_0002, 32'h0101_0003, -1);
    i_req = 1'b1; i_req_we = 1'b1; i_req_addr = 8'h01;
    @(posedge clk);
    @(negedge clk);
    check_val("pw_ack", 64'(o_req_ack), 64'd1);
    i_req = 1'b0;
    repeat (EXP_WAIT) @(negedge clk);
    i_wvalid = 1'b1; i_wdata = 32'hCAFE_0000; model[{8'h01, 2'd0}] = 32'hCAFE_0000;
    @(negedge clk);
    i_wdata = 32'hCAFE_0001; model[{8'h01, 2'd1}] = 32'hCAFE_0001;
    @(negedge clk);
    i_wvalid = 1'b0;
    nrst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    do_read(8'h01, 1'b0);

    // Top block boundary against block 0.
    do_write(8'h00, 32'h0000_AAAA, 32'h0000_BBBB, 32'h0000_CCCC, 32'h0000_DDDD, -1);
    do_write(8'hFF, 32'hFF00_0001, 32'hFF00_0002, 32'hFF00_0003, 32'hFF00_0004, 1);
    do_read(8'hFF, 1'b0);
    do_read(8'h00, 1'b0);

    // Random blocks, data and gap positions.
    for (int k = 0; k < 6; k++) begin
      logic [BLK_BITS-1:0] b;
      b = BLK_BITS'($urandom_range(16, 254));
      do_write(b, $urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, 4)) - 1);
      do_read(b, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    check_val("global_timeout", 64'd1, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
